// File: rtl/m14k_sleep_ctl_pkg.sv
// Shared definitions for the M14K WAIT/sleep controller: FSM state encoding
// and default timing parameters.
package m14k_sleep_ctl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SLEEP = 2'd2,
    ST_WAKE  = 2'd3
  } sleep_state_e;

  // Drain timeout in cycles (legal 2..255) and clock-restart settle cycles (legal 1..15).
  localparam int DRAIN_MAX_DEF = 64;
  localparam int WAKE_CYC_DEF  = 4;

endpackage

// File: rtl/m14k_sleep_ctl.sv
// WAIT-instruction sleep controller: drains the core, requests clock gate-off,
// and sequences the clock restart on an interrupt, NMI or debug request.
module m14k_sleep_ctl
  import m14k_sleep_ctl_pkg::*;
#(
  parameter int DRAIN_MAX = DRAIN_MAX_DEF,
  parameter int WAKE_CYC  = WAKE_CYC_DEF
) (
  input  logic gfclk,
  input  logic greset_n,
  input  logic mpc_wait_req,
  input  logic core_idle,
  input  logic cpz_int_pend,
  input  logic SI_NMI,
  input  logic EJ_DINT,
  input  logic gscanmode,
  output logic cpz_goodnight,
  output logic SI_Sleep,
  output logic mpc_wake,
  output logic mpc_wait_abort
);

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_MAX - 1);
  localparam logic [7:0] WAKE_LAST  = 8'(WAKE_CYC - 1);

  sleep_state_e state, next_state;
  logic [7:0]   cnt, cnt_nxt;
  logic         wake_nxt, abort_nxt;
  logic         wake_evt;

  assign wake_evt = cpz_int_pend | SI_NMI | EJ_DINT;

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a signal unassigned; otherwise synthesis infers a latch.
  always_comb begin
    next_state = state;
    cnt_nxt    = cnt;
    wake_nxt   = 1'b0;
    abort_nxt  = 1'b0;

    unique case (state)
      ST_RUN: begin
        if (mpc_wait_req) begin
          if (wake_evt) wake_nxt   = 1'b1;
          else          next_state = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (wake_evt) begin
          next_state = ST_RUN;
          wake_nxt   = 1'b1;
        end else if (core_idle) begin
          next_state = ST_SLEEP;
        end else if (cnt == DRAIN_LAST) begin
          next_state = ST_RUN;
          abort_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end

      ST_SLEEP: begin
        if (wake_evt) next_state = ST_WAKE;
      end

      // Once the clock restart has begun it always runs to completion.
      ST_WAKE: begin
        if (cnt == WAKE_LAST) begin
          next_state = ST_RUN;
          wake_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end

      default: next_state = ST_RUN;
    endcase

    if (next_state != state) cnt_nxt = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge gfclk or negedge greset_n) begin
    if (!greset_n) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are registered from the next state so they appear together with it.
  always_ff @(posedge gfclk or negedge greset_n) begin
    if (!greset_n) begin
      cpz_goodnight  <= 1'b0;
      SI_Sleep       <= 1'b0;
      mpc_wake       <= 1'b0;
      mpc_wait_abort <= 1'b0;
    end else begin
      cpz_goodnight  <= (next_state == ST_SLEEP) && !gscanmode;
      SI_Sleep       <= (next_state == ST_SLEEP) || (next_state == ST_WAKE);
      mpc_wake       <= wake_nxt;
      mpc_wait_abort <= abort_nxt;
    end
  end

endmodule
